// File: rtl/game_round_ctrl.sv
// Game-flow controller for the whack-a-mole core: synchronises the start/pause buttons
// and sequences IDLE -> READY countdown -> PLAY (with pause) across N_ROUNDS rounds -> DONE.
module game_round_ctrl #(
  parameter int N_ROUNDS    = 3,
  parameter int READY_TICKS = 3,
  parameter bit PAUSE_EN    = 1'b1,
  localparam int RW = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1,
  localparam int CW = (READY_TICKS > 0) ? $clog2(READY_TICKS + 1) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick_i,
  input  logic          start_btn_i,
  input  logic          pause_btn_i,
  input  logic          round_time_up_i,
  output logic          sys_reset_o,
  output logic          game_active_o,
  output logic          round_start_o,
  output logic [RW-1:0] round_idx_o,
  output logic [CW-1:0] countdown_o,
  output logic          game_done_o,
  output logic [2:0]    state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } stateT;

  localparam logic [RW-1:0] LAST_ROUND = RW'(N_ROUNDS - 1);
  localparam logic [CW-1:0] READY_CNT  = CW'(READY_TICKS);

  stateT         state_q, state_d;
  logic [CW-1:0] countdown_q, countdown_d;
  logic [RW-1:0] roundIdx_q, roundIdx_d;
  logic          roundStart_q, roundStart_d;

  logic [1:0]    startSync_q, pauseSync_q;
  logic          startPrev_q, pausePrev_q;
  logic          startPress, pausePress;

  // Sync chains reset to 1 so a button already held at reset release is not seen as a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      startSync_q <= 2'b11;
      pauseSync_q <= 2'b11;
      startPrev_q <= 1'b1;
      pausePrev_q <= 1'b1;
    end else begin
      startSync_q <= {startSync_q[0], start_btn_i};
      pauseSync_q <= {pauseSync_q[0], pause_btn_i};
      startPrev_q <= startSync_q[1];
      pausePrev_q <= pauseSync_q[1];
    end
  end

  assign startPress = startSync_q[1] & ~startPrev_q;
  assign pausePress = pauseSync_q[1] & ~pausePrev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      countdown_q  <= '0;
      roundIdx_q   <= '0;
      roundStart_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      countdown_q  <= countdown_d;
      roundIdx_q   <= roundIdx_d;
      roundStart_q <= roundStart_d;
    end
  end

  // Countdown defaults to zero so it only ever holds a value while in READY.
  always_comb begin
    state_d      = state_q;
    countdown_d  = '0;
    roundIdx_d   = roundIdx_q;
    roundStart_d = 1'b0;
    case (state_q)
      IDLE: begin
        roundIdx_d = '0;
        if (startPress) begin
          state_d     = READY;
          countdown_d = READY_CNT;
        end
      end
      READY: begin
        countdown_d = countdown_q;
        if (startPress) begin
          state_d     = IDLE;
          roundIdx_d  = '0;
          countdown_d = '0;
        end else if (READY_TICKS == 0) begin
          state_d      = PLAY;
          roundStart_d = 1'b1;
          countdown_d  = '0;
        end else if (tick_i) begin
          if (countdown_q <= CW'(1)) begin
            state_d      = PLAY;
            roundStart_d = 1'b1;
            countdown_d  = '0;
          end else begin
            countdown_d = countdown_q - CW'(1);
          end
        end
      end
      PLAY: begin
        if (startPress) begin
          state_d    = IDLE;
          roundIdx_d = '0;
        end else if (round_time_up_i) begin
          if (roundIdx_q == LAST_ROUND) begin
            state_d = DONE;
          end else begin
            state_d     = READY;
            roundIdx_d  = roundIdx_q + RW'(1);
            countdown_d = READY_CNT;
          end
        end else if (PAUSE_EN && pausePress) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (startPress) begin
          state_d    = IDLE;
          roundIdx_d = '0;
        end else if (pausePress) begin
          state_d = PLAY;
        end
      end
      DONE: begin
        if (startPress) begin
          state_d    = IDLE;
          roundIdx_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        roundIdx_d = '0;
      end
    endcase
  end

  assign sys_reset_o   = (state_q == IDLE);
  assign game_active_o = (state_q == PLAY);
  assign game_done_o   = (state_q == DONE);
  assign round_start_o = roundStart_q;
  assign round_idx_o   = roundIdx_q;
  assign countdown_o   = countdown_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl: expectations are queued as each cycle's stimulus is
// driven and compared after the clock edge; a PAUSE_EN=0 copy shares the same inputs.
module tb_game_round_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick, startBtn, pauseBtn, timeUp;
  logic       sysReset, gameActive, roundStart, gameDone;
  logic [1:0] roundIdx, countdown;
  logic [2:0] state;
  logic       sysReset2, gameActive2, roundStart2, gameDone2;
  logic [1:0] roundIdx2, countdown2;
  logic [2:0] state2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [1:0] cd;
    logic [1:0] idx;
    logic       rs;
  } expT;

  expT sbQ[$];

  game_round_ctrl #(.N_ROUNDS(3), .READY_TICKS(3), .PAUSE_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .tick_i(tick), .start_btn_i(startBtn),
    .pause_btn_i(pauseBtn), .round_time_up_i(timeUp), .sys_reset_o(sysReset),
    .game_active_o(gameActive), .round_start_o(roundStart), .round_idx_o(roundIdx),
    .countdown_o(countdown), .game_done_o(gameDone), .state_o(state)
  );

  game_round_ctrl #(.N_ROUNDS(3), .READY_TICKS(3), .PAUSE_EN(1'b0)) dutNoPause (
    .clk(clk), .reset(reset), .tick_i(tick), .start_btn_i(startBtn),
    .pause_btn_i(pauseBtn), .round_time_up_i(timeUp), .sys_reset_o(sysReset2),
    .game_active_o(gameActive2), .round_start_o(roundStart2), .round_idx_o(roundIdx2),
    .countdown_o(countdown2), .game_done_o(gameDone2), .state_o(state2)
  );

  always #5 clk = ~clk;

  task automatic compareField(input string tag, input string field,
                              input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  task automatic checkOutput();
    expT e;
    if (sbQ.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = sbQ.pop_front();
    compareField(e.tag, "state",      4'(state),      4'(e.st));
    compareField(e.tag, "countdown",  4'(countdown),  4'(e.cd));
    compareField(e.tag, "roundIdx",   4'(roundIdx),   4'(e.idx));
    compareField(e.tag, "roundStart", 4'(roundStart), 4'(e.rs));
    compareField(e.tag, "sysReset",   4'(sysReset),   4'(e.st == S_IDLE));
    compareField(e.tag, "gameActive", 4'(gameActive), 4'(e.st == S_PLAY));
    compareField(e.tag, "gameDone",   4'(gameDone),   4'(e.st == S_DONE));
  endtask

  task automatic applyStimulus(input logic tk, input logic st, input logic ps, input logic tu,
                               input string tag, input logic [2:0] eSt, input logic [1:0] eCd,
                               input logic [1:0] eIdx, input logic eRs);
    tick     = tk;
    startBtn = st;
    pauseBtn = ps;
    timeUp   = tu;
    sbQ.push_back('{tag, eSt, eCd, eIdx, eRs});
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Countdown from 3 to PLAY for the given round, ending one cycle after round_start.
  task automatic runCountdown(input string tag, input logic [1:0] idx);
    applyStimulus(1, 0, 0, 0, {tag, "_cd2"}, S_READY, 2'd2, idx, 1'b0);
    applyStimulus(1, 0, 0, 0, {tag, "_cd1"}, S_READY, 2'd1, idx, 1'b0);
    applyStimulus(1, 0, 0, 0, {tag, "_play"}, S_PLAY, 2'd0, idx, 1'b1);
    applyStimulus(0, 0, 0, 0, {tag, "_rsClr"}, S_PLAY, 2'd0, idx, 1'b0);
  endtask

  // One-cycle raw start pulse from IDLE; the press lands on the third edge.
  task automatic startGame(input string tag);
    applyStimulus(0, 1, 0, 0, {tag, "_a"}, S_IDLE, 2'd0, 2'd0, 1'b0);
    applyStimulus(0, 0, 0, 0, {tag, "_b"}, S_IDLE, 2'd0, 2'd0, 1'b0);
    applyStimulus(0, 0, 0, 0, {tag, "_ready"}, S_READY, 2'd3, 2'd0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    tick     = 1'b0;
    startBtn = 1'b1;
    pauseBtn = 1'b0;
    timeUp   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sbQ.push_back('{"inReset", S_IDLE, 2'd0, 2'd0, 1'b0});
    checkOutput();
    reset = 1'b0;

    // Start held across reset release must not register as a press
    repeat (4) applyStimulus(0, 1, 0, 0, "heldStart", S_IDLE, 2'd0, 2'd0, 1'b0);
    repeat (3) applyStimulus(0, 0, 0, 0, "release", S_IDLE, 2'd0, 2'd0, 1'b0);

    startGame("game1");
    applyStimulus(1, 0, 0, 0, "r0_cd2", S_READY, 2'd2, 2'd0, 1'b0);
    applyStimulus(0, 0, 0, 0, "r0_noTick", S_READY, 2'd2, 2'd0, 1'b0);
    applyStimulus(1, 0, 0, 0, "r0_cd1", S_READY, 2'd1, 2'd0, 1'b0);
    applyStimulus(1, 0, 0, 0, "r0_play", S_PLAY, 2'd0, 2'd0, 1'b1);
    applyStimulus(0, 0, 0, 0, "r0_rsClr", S_PLAY, 2'd0, 2'd0, 1'b0);

    applyStimulus(0, 0, 0, 1, "r0_timeUp", S_READY, 2'd3, 2'd1, 1'b0);
    runCountdown("r1", 2'd1);
    applyStimulus(0, 0, 0, 1, "r1_timeUp", S_READY, 2'd3, 2'd2, 1'b0);
    runCountdown("r2", 2'd2);

    // Pause in the last round; the no-pause copy must stay in PLAY
    applyStimulus(0, 0, 1, 0, "pause_a", S_PLAY, 2'd0, 2'd2, 1'b0);
    applyStimulus(0, 0, 0, 0, "pause_b", S_PLAY, 2'd0, 2'd2, 1'b0);
    applyStimulus(0, 0, 0, 0, "pause_in", S_PAUSE, 2'd0, 2'd2, 1'b0);
    compareField("noPause1", "state", 4'(state2), 4'(S_PLAY));
    compareField("noPause1", "gameActive", 4'(gameActive2), 4'd1);
    applyStimulus(1, 0, 0, 1, "pause_tuA", S_PAUSE, 2'd0, 2'd2, 1'b0);
    applyStimulus(0, 0, 0, 1, "pause_tuB", S_PAUSE, 2'd0, 2'd2, 1'b0);
    applyStimulus(0, 0, 1, 0, "resume_a", S_PAUSE, 2'd0, 2'd2, 1'b0);
    applyStimulus(0, 0, 0, 0, "resume_b", S_PAUSE, 2'd0, 2'd2, 1'b0);
    applyStimulus(0, 0, 0, 0, "resume", S_PLAY, 2'd0, 2'd2, 1'b0);
    applyStimulus(0, 0, 0, 1, "lastTimeUp", S_DONE, 2'd0, 2'd2, 1'b0);
    applyStimulus(0, 0, 0, 0, "doneHold", S_DONE, 2'd0, 2'd2, 1'b0);

    applyStimulus(0, 1, 0, 0, "doneStart_a", S_DONE, 2'd0, 2'd2, 1'b0);
    applyStimulus(0, 0, 0, 0, "doneStart_b", S_DONE, 2'd0, 2'd2, 1'b0);
    applyStimulus(0, 0, 0, 0, "doneToIdle", S_IDLE, 2'd0, 2'd0, 1'b0);

    // Start and pause pressed together in PLAY: start wins
    startGame("game2");
    runCountdown("g2r0", 2'd0);
    applyStimulus(0, 1, 1, 0, "both_a", S_PLAY, 2'd0, 2'd0, 1'b0);
    applyStimulus(0, 0, 0, 0, "both_b", S_PLAY, 2'd0, 2'd0, 1'b0);
    applyStimulus(0, 0, 0, 0, "bothAbort", S_IDLE, 2'd0, 2'd0, 1'b0);
    applyStimulus(0, 0, 0, 0, "gap1", S_IDLE, 2'd0, 2'd0, 1'b0);

    // Start press coinciding with the final tick: abort wins
    startGame("game3");
    applyStimulus(1, 0, 0, 0, "g3_cd2", S_READY, 2'd2, 2'd0, 1'b0);
    applyStimulus(1, 0, 0, 0, "g3_cd1", S_READY, 2'd1, 2'd0, 1'b0);
    applyStimulus(0, 1, 0, 0, "abort_a", S_READY, 2'd1, 2'd0, 1'b0);
    applyStimulus(0, 0, 0, 0, "abort_b", S_READY, 2'd1, 2'd0, 1'b0);
    applyStimulus(1, 0, 0, 0, "abortTick", S_IDLE, 2'd0, 2'd0, 1'b0);
    applyStimulus(0, 0, 0, 0, "abortIdle", S_IDLE, 2'd0, 2'd0, 1'b0);

    // Asynchronous reset mid-countdown
    startGame("game4");
    applyStimulus(1, 0, 0, 0, "g4_cd2", S_READY, 2'd2, 2'd0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    sbQ.push_back('{"asyncReset", S_IDLE, 2'd0, 2'd0, 1'b0});
    checkOutput();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) applyStimulus(0, 0, 0, 0, "postReset", S_IDLE, 2'd0, 2'd0, 1'b0);

    // Pause press with PAUSE_EN=0 has no effect
    startGame("game5");
    runCountdown("g5r0", 2'd0);
    applyStimulus(0, 0, 1, 0, "g5pause_a", S_PLAY, 2'd0, 2'd0, 1'b0);
    applyStimulus(0, 0, 0, 0, "g5pause_b", S_PLAY, 2'd0, 2'd0, 1'b0);
    applyStimulus(0, 0, 0, 0, "g5pause_in", S_PAUSE, 2'd0, 2'd0, 1'b0);
    compareField("noPause2", "state", 4'(state2), 4'(S_PLAY));
    compareField("noPause2", "gameActive", 4'(gameActive2), 4'd1);
    compareField("noPause2", "roundIdx", 4'(roundIdx2), 4'd0);

    checks++;
    assert (sbQ.size() == 0) else begin
      errors++;
      $error("[TB] FAIL scoreboardDrain observed=%0d expected=0", sbQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
